// File: rtl/alu_operand_pkg.sv
// Shared types and field positions for the ALU operand stage: source-code enum,
// register-port tags used for writeback forwarding, and RV immediate field offsets.
package alu_operand_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    SRC_ZERO   = 4'd0,
    SRC_FOUR   = 4'd1,
    SRC_PC     = 4'd2,
    SRC_RS1    = 4'd3,
    SRC_IMM_I  = 4'd4,
    SRC_IMM_U  = 4'd5,
    SRC_IMM_J  = 4'd6,
    SRC_IMM_B  = 4'd7,
    SRC_IMM_S  = 4'd8,
    SRC_RS2    = 4'd9,
    SRC_SHAMT  = 4'd10,
    SRC_ZIMM   = 4'd11,
    SRC_RSVD12 = 4'd12,
    SRC_RSVD13 = 4'd13,
    SRC_RSVD14 = 4'd14,
    SRC_RSVD15 = 4'd15
  } src_e;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RS1  = 2'd1,
    REG_RS2  = 2'd2
  } reg_sel_e;

  localparam int IMM_SIGN_BIT = 31;
  localparam int SHAMT_LSB    = 20;
  localparam int ZIMM_LSB     = 15;
  localparam int ZIMM_W       = 5;

  // Which register-file port an operand depends on (drives forwarding match).
  function automatic reg_sel_e reg_sel_of(input logic [3:0] src);
    case (src)
      SRC_RS1: return REG_RS1;
      SRC_RS2: return REG_RS2;
      default: return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stage_operand_select.sv
// Combinational decode of one operand from its 4-bit source code.
// Reserved codes 12-15 yield zero and raise illegal.
module operand_select
  import alu_operand_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      src,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] imm_s;
  logic        unused_opcode;

  // Immediates are first formed at 32 bits with instr[31] replicated; sext32 widens to XLEN.
  assign imm_i = {{20{instr[IMM_SIGN_BIT]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[IMM_SIGN_BIT]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{19{instr[IMM_SIGN_BIT]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_s = {{20{instr[IMM_SIGN_BIT]}}, instr[31:25], instr[11:7]};

  assign unused_opcode = ^instr[6:0];

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [XLEN-1:0] r;
    r = XLEN'($signed(v));
    return r;
  endfunction

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (src_e'(src))
      SRC_ZERO:  data = '0;
      SRC_FOUR:  data = XLEN'(4);
      SRC_PC:    data = instr_addr;
      SRC_RS1:   data = rs1_data;
      SRC_IMM_I: data = sext32(imm_i);
      SRC_IMM_U: data = sext32(imm_u);
      SRC_IMM_J: data = sext32(imm_j);
      SRC_IMM_B: data = sext32(imm_b);
      SRC_IMM_S: data = sext32(imm_s);
      SRC_RS2:   data = rs2_data;
      SRC_SHAMT: data = XLEN'(instr[SHAMT_LSB +: SHAMT_W]);
      SRC_ZIMM:  data = XLEN'(instr[ZIMM_LSB +: ZIMM_W]);
      default: begin
        data    = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage: two operand decoders feeding a 2-entry skid buffer.
// Optional writeback forwarding is enabled with `define ALU_OPERAND_FWD_EN.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_addr,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_OPERAND_FWD_EN
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            op_illegal
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("alu_operand_stage: DEPTH must be 2");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("alu_operand_stage: XLEN must be 32 or 64");
  end

  logic [1:0]      count_reg;
  logic            rd_ptr_reg;
  logic            wr_ptr_reg;
  logic            accept;
  logic            release_head;
  logic [XLEN-1:0] rs1_eff;
  logic [XLEN-1:0] rs2_eff;
  logic [XLEN-1:0] a_dec;
  logic [XLEN-1:0] b_dec;
  logic            a_ill;
  logic            b_ill;
  logic [XLEN-1:0] head_a;
  logic [XLEN-1:0] head_b;
  logic            head_ill;

`ifdef ALU_OPERAND_FWD_EN
  logic fwd_rs1;
  logic fwd_rs2;
  assign fwd_rs1 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_idx);
  assign fwd_rs2 = wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_idx);
  assign rs1_eff = fwd_rs1 ? wb_data : rs1_data;
  assign rs2_eff = fwd_rs2 ? wb_data : rs2_data;
`else
  logic unused_idx;
  assign unused_idx = ^{rs1_idx, rs2_idx};
  assign rs1_eff    = rs1_data;
  assign rs2_eff    = rs2_data;
`endif

  operand_select #(.XLEN(XLEN)) u_sel_a (
    .src        (src_a),
    .instr      (instr),
    .instr_addr (instr_addr),
    .rs1_data   (rs1_eff),
    .rs2_data   (rs2_eff),
    .data       (a_dec),
    .illegal    (a_ill)
  );

  operand_select #(.XLEN(XLEN)) u_sel_b (
    .src        (src_b),
    .instr      (instr),
    .instr_addr (instr_addr),
    .rs1_data   (rs1_eff),
    .rs2_data   (rs2_eff),
    .data       (b_dec),
    .illegal    (b_ill)
  );

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready     = (count_reg < 2'd2);
  assign out_valid    = (count_reg != 2'd0);
  assign accept       = in_valid && in_ready && !flush;
  assign release_head = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (flush) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (release_head) rd_ptr_reg <= ~rd_ptr_reg;
      case ({accept, release_head})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic            ill_reg;
    logic            wr_en;

    assign wr_en = accept && (wr_ptr_reg == 1'(gi));

`ifdef ALU_OPERAND_FWD_EN
    reg_sel_e   a_sel_reg;
    reg_sel_e   b_sel_reg;
    logic [4:0] rs1_idx_reg;
    logic [4:0] rs2_idx_reg;
    logic       hit_a;
    logic       hit_b;

    // Waiting entries pick up a late writeback to the register they read.
    assign hit_a = wb_valid && (wb_rd != 5'd0) &&
                   (((a_sel_reg == REG_RS1) && (wb_rd == rs1_idx_reg)) ||
                    ((a_sel_reg == REG_RS2) && (wb_rd == rs2_idx_reg)));
    assign hit_b = wb_valid && (wb_rd != 5'd0) &&
                   (((b_sel_reg == REG_RS1) && (wb_rd == rs1_idx_reg)) ||
                    ((b_sel_reg == REG_RS2) && (wb_rd == rs2_idx_reg)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_reg       <= '0;
        b_reg       <= '0;
        ill_reg     <= 1'b0;
`ifdef ALU_OPERAND_FWD_EN
        a_sel_reg   <= REG_NONE;
        b_sel_reg   <= REG_NONE;
        rs1_idx_reg <= 5'd0;
        rs2_idx_reg <= 5'd0;
`endif
      end else if (wr_en) begin
        a_reg       <= a_dec;
        b_reg       <= b_dec;
        ill_reg     <= a_ill | b_ill;
`ifdef ALU_OPERAND_FWD_EN
        a_sel_reg   <= reg_sel_of(src_a);
        b_sel_reg   <= reg_sel_of(src_b);
        rs1_idx_reg <= rs1_idx;
        rs2_idx_reg <= rs2_idx;
      end else begin
        if (hit_a) a_reg <= wb_data;
        if (hit_b) b_reg <= wb_data;
`endif
      end
    end
  end

  assign head_a   = rd_ptr_reg ? g_entry[1].a_reg   : g_entry[0].a_reg;
  assign head_b   = rd_ptr_reg ? g_entry[1].b_reg   : g_entry[0].b_reg;
  assign head_ill = rd_ptr_reg ? g_entry[1].ill_reg : g_entry[0].ill_reg;

  assign op_a       = out_valid ? head_a : '0;
  assign op_b       = out_valid ? head_b : '0;
  assign op_illegal = out_valid & head_ill;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: XLEN=32 and XLEN=64 instances share stimulus.
// Build with +define+ALU_OPERAND_FWD_EN to also exercise writeback forwarding.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        in_ready32, out_valid32, op_illegal32;
  logic [31:0] op_a32, op_b32;
  logic        in_ready64, out_valid64, op_illegal64;
  logic [63:0] op_a64, op_b64;

`ifdef ALU_OPERAND_FWD_EN
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_operand_stage #(.XLEN(32)) dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready32),
    .src_a      (src_a),
    .src_b      (src_b),
    .instr      (instr),
    .instr_addr (instr_addr),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
`ifdef ALU_OPERAND_FWD_EN
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
`endif
    .out_valid  (out_valid32),
    .out_ready  (out_ready),
    .op_a       (op_a32),
    .op_b       (op_b32),
    .op_illegal (op_illegal32)
  );

  alu_operand_stage #(.XLEN(64)) dut64 (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready64),
    .src_a      (src_a),
    .src_b      (src_b),
    .instr      (instr),
    .instr_addr ({32'h0, instr_addr}),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_data   ({32'h0, rs1_data}),
    .rs2_data   ({32'h0, rs2_data}),
`ifdef ALU_OPERAND_FWD_EN
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    ({32'h0, wb_data}),
`endif
    .out_valid  (out_valid64),
    .out_ready  (out_ready),
    .op_a       (op_a64),
    .op_b       (op_b64),
    .op_illegal (op_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eill;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] sa, input logic [3:0] sb, input logic [31:0] ins,
                        input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    src_a      = sa;
    src_b      = sb;
    instr      = ins;
    instr_addr = pc;
    rs1_data   = r1;
    rs2_data   = r2;
  endtask

  initial begin
    vecs[0] = '{4'd2,  4'd4,  32'hFFF00093, 32'h100, 32'h11111111, 32'h22222222, 32'h00000100, 32'hFFFFFFFF, 1'b0};
    vecs[1] = '{4'd0,  4'd1,  32'hFFF00093, 32'h100, 32'h11111111, 32'h22222222, 32'h00000000, 32'h00000004, 1'b0};
    vecs[2] = '{4'd3,  4'd9,  32'hFFF00093, 32'h100, 32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222, 1'b0};
    vecs[3] = '{4'd5,  4'd10, 32'h12345037, 32'h100, 32'h0,        32'h0,        32'h12345000, 32'h00000003, 1'b0};
    vecs[4] = '{4'd6,  4'd7,  32'h8000006F, 32'h100, 32'h0,        32'h0,        32'hFFF00000, 32'hFFFFF000, 1'b0};
    vecs[5] = '{4'd8,  4'd11, 32'h000F8F80, 32'h100, 32'h0,        32'h0,        32'h0000001F, 32'h0000001F, 1'b0};
    vecs[6] = '{4'd13, 4'd15, 32'hFFFFFFFF, 32'h100, 32'h5,        32'h6,        32'h00000000, 32'h00000000, 1'b1};
    vecs[7] = '{4'd12, 4'd0,  32'h00000000, 32'h100, 32'h5,        32'h6,        32'h00000000, 32'h00000000, 1'b1};
    vecs[8] = '{4'd4,  4'd5,  32'h7FF00013, 32'h100, 32'h0,        32'h0,        32'h000007FF, 32'h7FF00000, 1'b0};
    vecs[9] = '{4'd6,  4'd7,  32'h00000F80, 32'h100, 32'h0,        32'h0,        32'h00000000, 32'h0000081E, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rs1_idx   = 5'd0;
    rs2_idx   = 5'd0;
    set_in(4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ALU_OPERAND_FWD_EN
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'h0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'h0, out_valid32}, 64'h0);
    chk("reset_in_ready", {63'h0, in_ready32}, 64'h1);
    chk("reset_op_a", {32'h0, op_a32}, 64'h0);
    chk("reset_op_illegal", {63'h0, op_illegal32}, 64'h0);
    chk("reset_out_valid64", {63'h0, out_valid64}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_in_ready", {63'h0, in_ready32}, 64'h1);

    // Table vectors: one accept, check next-cycle outputs, then drain.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_in(vecs[i].sa, vecs[i].sb, vecs[i].ins, vecs[i].pc, vecs[i].r1, vecs[i].r2);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      $display("vec %0d: src_a=%0d src_b=%0d instr=%h -> op_a=%h op_b=%h ill=%0d",
               i, vecs[i].sa, vecs[i].sb, vecs[i].ins, op_a32, op_b32, op_illegal32);
      chk($sformatf("vec%0d_out_valid", i), {63'h0, out_valid32}, 64'h1);
      chk($sformatf("vec%0d_op_a", i), {32'h0, op_a32}, {32'h0, vecs[i].ea});
      chk($sformatf("vec%0d_op_b", i), {32'h0, op_b32}, {32'h0, vecs[i].eb});
      chk($sformatf("vec%0d_op_illegal", i), {63'h0, op_illegal32}, {63'h0, vecs[i].eill});
      @(negedge clk);
      in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_drained", i), {62'h0, out_valid32, op_illegal32}, 64'h0);
    end

    // XLEN=64 sign extension and 6-bit shamt.
    @(negedge clk);
    set_in(4'd0, 4'd7, 32'h80000063, 32'h0, 32'h0, 32'h0);
    in_valid = 1'b1;
    tick();
    $display("x64 B-offset: op_b64=%h", op_b64);
    chk("x64_b_offset", op_b64, 64'hFFFF_FFFF_FFFF_F000);
    chk("x32_b_offset", {32'h0, op_b32}, 64'h0000_0000_FFFF_F000);
    @(negedge clk);
    set_in(4'd5, 4'd10, 32'h83F00037, 32'h0, 32'h0, 32'h0);
    tick();
    $display("x64 U/shamt: op_a64=%h op_b64=%h op_b32=%h", op_a64, op_b64, op_b32);
    chk("x64_u_imm", op_a64, 64'hFFFF_FFFF_83F0_0000);
    chk("x64_shamt", op_b64, 64'd63);
    chk("x32_shamt", {32'h0, op_b32}, 64'd31);
    @(negedge clk);
    in_valid = 1'b0;
    tick();

    // Backpressure: three pushes with out_ready low, then in-order release.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(4'd2, 4'd0, 32'h0, 32'h200, 32'h0, 32'h0);
    tick();
    $display("bp push1: in_ready=%0d op_a=%h", in_ready32, op_a32);
    chk("bp1_in_ready", {63'h0, in_ready32}, 64'h1);
    chk("bp1_op_a", {32'h0, op_a32}, 64'h200);
    @(negedge clk);
    instr_addr = 32'h204;
    tick();
    $display("bp push2: in_ready=%0d op_a=%h", in_ready32, op_a32);
    chk("bp2_in_ready", {63'h0, in_ready32}, 64'h0);
    chk("bp2_op_a_held", {32'h0, op_a32}, 64'h200);
    @(negedge clk);
    instr_addr = 32'h208;
    tick();
    $display("bp push3 stalled: in_ready=%0d op_a=%h", in_ready32, op_a32);
    chk("bp3_in_ready", {63'h0, in_ready32}, 64'h0);
    chk("bp3_op_a_held", {32'h0, op_a32}, 64'h200);
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    $display("bp release1: op_a=%h in_ready=%0d", op_a32, in_ready32);
    chk("bp_rel1_op_a", {32'h0, op_a32}, 64'h204);
    chk("bp_rel1_in_ready", {63'h0, in_ready32}, 64'h1);
    tick();
    $display("bp release2+accept3: op_a=%h", op_a32);
    chk("bp_rel2_op_a", {32'h0, op_a32}, 64'h208);
    chk("bp_rel2_out_valid", {63'h0, out_valid32}, 64'h1);
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {63'h0, out_valid32}, 64'h0);

    // Streaming at full rate.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      set_in(4'd2, 4'd1, 32'h0, 32'h300 + 32'(4 * k), 32'h0, 32'h0);
      tick();
      $display("stream %0d: op_a=%h in_ready=%0d", k, op_a32, in_ready32);
      chk($sformatf("stream%0d_op_a", k), {32'h0, op_a32}, {32'h0, 32'h300 + 32'(4 * k)});
      chk($sformatf("stream%0d_in_ready", k), {63'h0, in_ready32}, 64'h1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {63'h0, out_valid32}, 64'h0);

    // Flush with a full buffer and a same-cycle input.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(4'd2, 4'd0, 32'h0, 32'h400, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    instr_addr = 32'h404;
    tick();
    chk("flush_full", {63'h0, in_ready32}, 64'h0);
    @(negedge clk);
    flush      = 1'b1;
    instr_addr = 32'hBAD;
    tick();
    $display("flush: out_valid=%0d in_ready=%0d op_a=%h", out_valid32, in_ready32, op_a32);
    chk("flush_out_valid", {63'h0, out_valid32}, 64'h0);
    chk("flush_in_ready", {63'h0, in_ready32}, 64'h1);
    chk("flush_op_a", {32'h0, op_a32}, 64'h0);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("flush_dropped_absent", {63'h0, out_valid32}, 64'h0);
    @(negedge clk);
    in_valid   = 1'b1;
    instr_addr = 32'h500;
    tick();
    chk("post_flush_op_a", {32'h0, op_a32}, 64'h500);
    @(negedge clk);
    in_valid = 1'b0;
    tick();

`ifdef ALU_OPERAND_FWD_EN
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    set_in(4'd3, 4'd0, 32'h0, 32'h0, 32'h1234, 32'h0);
    rs1_idx  = 5'd5;
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'hDEAD;
    tick();
    $display("fwd hit: op_a=%h", op_a32);
    chk("fwd_hit_op_a", {32'h0, op_a32}, 64'hDEAD);
    @(negedge clk);
    wb_rd   = 5'd0;
    rs1_idx = 5'd0;
    tick();
    $display("fwd x0: op_a=%h", op_a32);
    chk("fwd_x0_op_a", {32'h0, op_a32}, 64'h1234);
    @(negedge clk);
    in_valid = 1'b0;
    wb_valid = 1'b0;
    tick();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rs1_idx   = 5'd7;
    rs1_data  = 32'h1;
    tick();
    chk("fwd_buf_before", {32'h0, op_a32}, 64'h1);
    @(negedge clk);
    in_valid = 1'b0;
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    wb_data  = 32'hBEEF;
    tick();
    $display("fwd in-place: op_a=%h", op_a32);
    chk("fwd_buf_updated", {32'h0, op_a32}, 64'hBEEF);
    @(negedge clk);
    wb_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
